// File: rtl/sign_mult.sv
// Sequential 16x16 signed multiplier: sign/magnitude split, 16-step shift-add, sign fix-up.
// Optional macro SIGN_MULT_ZERO_SKIP_EN short-circuits zero operands straight to DONE.
module sign_mult (
    input  logic        CLK,
    input  logic        Rst,
    input  logic        St,
    input  logic [15:0] Dbus,
    output logic [31:0] Product,
    output logic        Rdy,
    output logic        Busy
);

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOADB = 3'd1,
        SIGN  = 3'd2,
        MULT  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t                state;
    logic [DATA_W-1:0]     opa;
    logic [DATA_W-1:0]     opb;
    logic                  sgn;
    logic [2*DATA_W-1:0]   acc;
    logic [4:0]            cnt;
    logic [DATA_W:0]       sum;

    // 0x8000 maps to 0x8000, read as the unsigned value 32768.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] u;
        u = v;
        return v[DATA_W-1] ? (~u + 16'd1) : u;
    endfunction

    function automatic logic [2*DATA_W-1:0] negate32(input logic [2*DATA_W-1:0] v);
        return ~v + 32'd1;
    endfunction

    // Carry out of the upper-half add is kept and shifted back into bit 31.
    assign sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (opb[0] ? {1'b0, opa} : 17'd0);

    always_ff @(posedge CLK) begin
        if (Rst) begin
            state   <= IDLE;
            Product <= '0;
            Rdy     <= 1'b0;
            Busy    <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            sgn     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (St) begin
                        opa   <= Dbus;
                        Rdy   <= 1'b0;
                        state <= LOADB;
                    end
                end
                LOADB: begin
                    opb   <= Dbus;
                    Busy  <= 1'b1;
                    state <= SIGN;
                end
                SIGN: begin
                    sgn <= opa[DATA_W-1] ^ opb[DATA_W-1];
                    opa <= magnitude(opa);
                    opb <= magnitude(opb);
                    acc <= '0;
                    cnt <= '0;
`ifdef SIGN_MULT_ZERO_SKIP_EN
                    if (opa == '0 || opb == '0) begin
                        Product <= '0;
                        Rdy     <= 1'b1;
                        Busy    <= 1'b0;
                        state   <= DONE;
                    end else begin
                        state <= MULT;
                    end
`else
                    state <= MULT;
`endif
                end
                MULT: begin
                    acc <= {sum, acc[DATA_W-1:1]};
                    opb <= opb >> 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15)
                        state <= FIX;
                end
                FIX: begin
                    Product <= sgn ? negate32(acc) : acc;
                    Rdy     <= 1'b1;
                    Busy    <= 1'b0;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sign_mult.sv
// Directed and randomized bench for sign_mult with an expected-product queue.
module tb_sign_mult;

    logic        CLK = 1'b0;
    logic        Rst;
    logic        St;
    logic [15:0] Dbus;
    logic [31:0] Product;
    logic        Rdy;
    logic        Busy;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    int last_edges;
    int busy_bad;

    sign_mult dut (
        .CLK    (CLK),
        .Rst    (Rst),
        .St     (St),
        .Dbus   (Dbus),
        .Product(Product),
        .Rdy    (Rdy),
        .Busy   (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        int sa;
        int sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        return 32'(sa * sb);
    endfunction

    function automatic int latency(input logic [15:0] a, input logic [15:0] b);
`ifdef SIGN_MULT_ZERO_SKIP_EN
        if (a == 16'd0 || b == 16'd0) return 3;
`endif
        return 20;
    endfunction

    // Called at a negedge; returns at the negedge after edge 1.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic hold_st);
        St   = 1'b1;
        Dbus = a;
        @(negedge CLK);
        St   = hold_st;
        Dbus = b;
    endtask

    // Waits for Rdy, tracking the edge count and Busy profile, then checks the result.
    task automatic finish_op(input string tag, input int exp_lat);
        int edges;
        logic [31:0] expv;
        edges    = 1;
        busy_bad = 0;
        while (!Rdy && edges < 60) begin
            @(negedge CLK);
            edges++;
            if (!Rdy && Busy !== (edges >= 2)) busy_bad++;
        end
        if (Busy !== 1'b0) busy_bad++;
        last_edges = edges;
        check({tag, "_latency"}, 32'(edges), 32'(exp_lat));
        check({tag, "_busy"}, 32'(busy_bad), 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            expv = exp_q.pop_front();
            check({tag, "_product"}, Product, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b);
        exp_q.push_back(model(a, b));
        start_op(a, b, 1'b0);
        finish_op(tag, latency(a, b));
    endtask

    initial begin
        logic [31:0] held;
        logic [15:0] ra;
        logic [15:0] rb;

        Rst  = 1'b1;
        St   = 1'b1;
        Dbus = 16'hFFFF;
        repeat (3) @(negedge CLK);
        check("reset_product", Product, 32'd0);
        check("reset_rdy", {31'd0, Rdy}, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);

        // St on the first edge after reset release starts normally.
        Rst = 1'b0;
        run_op("sign", 16'd7, 16'hFFFD);
        check("sign_value", Product, 32'hFFFF_FFEB);

        // DONE with St=0 holds outputs.
        held = Product;
        repeat (4) @(negedge CLK);
        check("hold_product", Product, held);
        check("hold_rdy", {31'd0, Rdy}, 32'd1);

        run_op("ext_neg_neg", 16'h8000, 16'h8000);
        check("ext_neg_neg_value", Product, 32'h4000_0000);
        run_op("ext_pos_neg", 16'h7FFF, 16'h8000);
        check("ext_pos_neg_value", Product, 32'hC000_8000);
        run_op("zero_a", 16'd0, 16'd1234);
        run_op("zero_b", 16'hFFFF, 16'd0);
        run_op("neg_one_sq", 16'hFFFF, 16'hFFFF);
        run_op("max_sq", 16'h7FFF, 16'h7FFF);

        // Reset at edge 10 of an operation aborts it.
        start_op(16'd100, 16'd200, 1'b0);
        repeat (8) @(negedge CLK);
        Rst = 1'b1;
        @(negedge CLK);
        Rst = 1'b0;
        check("abort_product", Product, 32'd0);
        check("abort_rdy", {31'd0, Rdy}, 32'd0);
        check("abort_busy", {31'd0, Busy}, 32'd0);
        repeat (25) @(negedge CLK);
        check("abort_stays_idle", {31'd0, Rdy}, 32'd0);
        run_op("after_abort", 16'd100, 16'd200);
        check("after_abort_value", Product, 32'd20000);

        // St held high across a whole operation.
        exp_q.push_back(model(16'd5, 16'd6));
        start_op(16'd5, 16'd6, 1'b1);
        finish_op("st_held", 20);
        @(negedge CLK);
        check("st_held_restart_rdy", {31'd0, Rdy}, 32'd0);
        check("st_held_product_kept", Product, 32'd30);
        St   = 1'b0;
        Dbus = 16'd6;
        exp_q.push_back(model(16'd6, 16'd6));
        finish_op("st_held_second", 20);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 97 == 0) ra = 16'd0;
            run_op("random", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
